multicycle_control: RTL

- Multi-cycle control unit for the RV32I core. Replaces single-cycle opcode decode with a registered state machine.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB using a req/ready handshake to a shared instruction/data memory.
- Adds BNE and JAL (parameter-gated), illegal-opcode and memory-timeout trapping, and a retired-instruction counter.
- Drives the multi-cycle datapath muxes, register file, IR and PC write enables.

---
 rtl/multicycle_control_if.sv | 15 +
 rtl/multicycle_control.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multi-cycle control unit and the shared
// instruction/data memory.
//   mem_req   : access request (controller -> memory)
//   mem_wr    : 1 = store, 0 = read; meaningful while mem_req=1
//   iord      : address select, 0 = PC, 1 = ALU result register
//   mem_ready : memory completes the current access this cycle (memory -> controller)
interface multicycle_control_if;
  logic mem_req;
  logic mem_wr;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_wr, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_wr, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the RV32I core. Sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB, handshaking with a shared memory, and traps
// on unsupported opcodes or a memory access that never completes.
// Ports:
//   clk, n_rst     : clock (rising edge) and asynchronous active-low reset
//   mem            : memory handshake (req/wr/iord out, ready in)
//   opcode, funct3 : IR fields, stable from DECODE onward
//   zero           : ALU zero flag, valid in EXEC
//   ir_wr, reg_wr, mem_to_reg, alu_src_b, alu_op, pc_wr, pc_src : datapath controls
//   state          : current state for debug
//   illegal, mem_err : sticky trap causes
//   instret        : retired-instruction counter (wraps)
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter bit          EN_JAL      = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  multicycle_control_if.master mem,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  output logic                 ir_wr,
  output logic                 reg_wr,
  output logic [1:0]           mem_to_reg,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 pc_wr,
  output logic                 pc_src,
  output logic [2:0]           state,
  output logic                 illegal,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     instret
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // The wait counter only has to reach MEM_TIMEOUT-1 before a trap fires.
  localparam int unsigned       WAIT_W    = (MEM_TIMEOUT > 32'd1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 32'd0) ? (MEM_TIMEOUT - 32'd1) : 32'd0);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              illegal_q, illegal_d;
  logic              mem_err_q, mem_err_d;
  logic              timeout_s;

  // Supported opcode/funct3 combinations; BRANCH covers only BEQ and BNE.
  function automatic logic op_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE: ok = 1'b1;
      OP_BRANCH: ok = (f3 == 3'b000) || (f3 == 3'b001);
      OP_JAL:    ok = EN_JAL;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // A stalled access times out on its MEM_TIMEOUT-th cycle unless ready arrives then.
  assign timeout_s = (MEM_TIMEOUT != 32'd0) && (wait_q == WAIT_LAST) && !mem.mem_ready;

  // Next-state and control strobe decode.
  always_comb begin
    state_d        = state_q;
    illegal_d      = illegal_q;
    mem_err_d      = mem_err_q;
    mem.mem_req    = 1'b0;
    mem.mem_wr     = 1'b0;
    mem.iord       = 1'b0;
    ir_wr          = 1'b0;
    reg_wr         = 1'b0;
    mem_to_reg     = 2'b00;
    alu_src_b      = 1'b0;
    alu_op         = 2'b00;
    pc_wr          = 1'b0;
    pc_src         = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_wr   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d   = S_TRAP;
          mem_err_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (op_legal(opcode, funct3)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          OP_ITYPE: begin
            alu_src_b = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            alu_op  = 2'b01;
            pc_wr   = 1'b1;
            pc_src  = (funct3 == 3'b000) ? zero : ~zero;
            state_d = S_FETCH;
          end
          OP_JAL: begin
            if (EN_JAL) begin
              reg_wr     = 1'b1;
              mem_to_reg = 2'b10;
              pc_wr      = 1'b1;
              pc_src     = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          end
          // IR changed under us after DECODE: refuse to execute it.
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        mem.mem_wr  = (opcode == OP_STORE);
        if (mem.mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_wr   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_s) begin
          state_d   = S_TRAP;
          mem_err_d = 1'b1;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        pc_wr      = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      // Unused encoding 7 is treated as a fault.
      default: state_d = S_TRAP;
    endcase
  end

  // Stall counter: counts unanswered request cycles, cleared on every state change.
  always_comb begin
    if (state_d != state_q) begin
      wait_d = {WAIT_W{1'b0}};
    end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem.mem_ready) begin
      wait_d = wait_q + WAIT_ONE;
    end else begin
      wait_d = wait_q;
    end
  end

  // Every PC write ends an instruction, so it is the retire event.
  always_comb begin
    if (pc_wr) begin
      instret_d = instret_q + CNT_ONE;
    end else begin
      instret_d = instret_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      wait_q    <= {WAIT_W{1'b0}};
      instret_q <= {CNT_W{1'b0}};
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign mem_err = mem_err_q;
  assign instret = instret_q;

endmodule
